neuron_buffer_sequencer: RTL and testbench
==========================================

# neuron_buffer_sequencer

Control stage directly upstream of the neuron buffer swapper. It generates the buffer-select, read/write addresses and write strobes that the swapper routes to the two ping-pong neuron buffers. For one layer pass it streams read addresses out of the current read buffer and writes the compute pipeline's results into the other buffer at a fixed latency. It then toggles the buffer roles so the next layer reads what was just written. While idle it passes host IO address and write strobes through to the read buffer.

## Interface
Parameters:
- `depth`, 2: log2 of words per buffer row; passed through for `D`.
- `A`, 7: buffer address width.
- `LAT`, 3: compute-pipeline latency in cycles from read address to write strobe; legal range 1..15.

Ports:
- `clk`  in  1  single clock; every register updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a layer pass.
- `layerLength`  in  A  number of rows to process; sampled on accepted `start`.
- `doPoolingIn`  in  1  pooling mode for the pass; sampled on accepted `start`.
- `ioAddress`  in  A  host address into the read buffer, used in IDLE only.
- `ioWrite`  in  1  host write strobe into the read buffer, used in IDLE only.
- `readBufferSelect`  out  1  0: N1 is read, N2 is written; 1: the reverse.
- `doPooling`  out  1  latched pooling mode.
- `readBuffAddress`  out  A  read-buffer address.
- `writeBuffAddress`  out  A  write-buffer address.
- `nRWrite`  out  1  read-buffer write enable.
- `nWWrite`  out  1  write-buffer write enable.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `done`  out  1  one-cycle pulse marking the end of a pass.

## Operation
- FSM states: IDLE, READ, DRAIN, SWAP.
- IDLE:
  - `readBuffAddress` = `ioAddress` and `nRWrite` = `ioWrite`, both combinational pass-through.
  - `nWWrite` = 0 and `writeBuffAddress` = 0.
- Start acceptance:
  - `start` is accepted only in IDLE and only with `layerLength` != 0.
  - `start` with length 0, or `start` in any other state, is ignored: no state change, no `done`.
- On an accepted start: latch `L` = `layerLength` and `doPooling` = `doPoolingIn`; reset the read counter; go to READ.
- READ:
  - `readBuffAddress` = read counter, which increments by 1 each cycle from 0 to L-1.
  - `nRWrite` = 0.
  - A valid bit is pushed into a LAT-deep shift register each cycle.
  - After address L-1 is issued, go to DRAIN.
- DRAIN:
  - `readBuffAddress` holds L-1; the shift register receives 0s.
- Write side, in READ and DRAIN:
  - `nWWrite` = the shift-register output.
  - A write counter starts at 0 and increments after each cycle where `nWWrite` is high; `writeBuffAddress` = write counter.
  - In the cycle the L-th write is issued, go to SWAP.
- SWAP (exactly one cycle):
  - `done` = 1; `nWWrite` = 0.
  - `readBufferSelect` toggles on the clock edge that leaves SWAP; next state IDLE.
- `doPooling` holds its latched value through IDLE until the next accepted start.
- Address width: counters are A bits. L = 2^A is not representable; the maximum pass is 2^A-1 rows.

## Timing
- Reset values: `readBufferSelect`=0, `doPooling`=0, `busy`=0, `done`=0, `nWWrite`=0, `writeBuffAddress`=0, FSM=IDLE, counters and shift register cleared.
- Because the FSM is in IDLE after reset, `readBuffAddress`/`nRWrite` follow `ioAddress`/`ioWrite` from the first cycle after reset.
- Accepted `start` in cycle t:
  - `busy` rises at t+1.
  - `readBuffAddress` = i in cycle t+1+i, for i = 0..L-1.
  - `nWWrite` = 1 with `writeBuffAddress` = i in cycle t+1+LAT+i.
  - SWAP and `done` in cycle t+LAT+L+1.
  - New `readBufferSelect` and `busy`=0 from cycle t+LAT+L+2; the earliest new start is also t+LAT+L+2.
- `reset` asserted mid-pass:
  - Next cycle all outputs are at their reset values, including `readBufferSelect`=0.
  - Pending shifted writes are discarded; no `done` is produced.
- `reset` and `start` asserted in the same cycle: reset wins.

## Test plan
- Reset → `readBufferSelect`=0, `busy`=0, `done`=0, `nWWrite`=0. In IDLE, `ioAddress`=5, `ioWrite`=1 → same cycle `readBuffAddress`=5, `nRWrite`=1.
- LAT=3, L=4, `start` at cycle 10 → read addresses 0..3 in cycles 11..14; `nWWrite` with addresses 0..3 in cycles 14..17; `done` at 18; `readBufferSelect`=1 from 19.
- Two back-to-back passes (second `start` in the first cycle back in IDLE) → select goes 0→1→0; `doPooling` follows each sampled `doPoolingIn` (1, then 0).
- `start` with `layerLength`=0, and `start` pulsed during READ → both ignored: pass length unchanged, exactly one `done`.
- `reset` in the cycle of the 2nd write of an L=4 pass → no further `nWWrite`, no `done`, `readBufferSelect`=0.
- L=127 (A=7) → final write at address 126, no counter wrap, `done` at t+LAT+128.

Source files
------------

// File: rtl/neuron_buffer_sequencer.sv
// Ping-pong neuron buffer sequencer: streams read addresses for one layer pass,
// issues result writes LAT cycles later into the other buffer, then swaps roles.
module neuron_buffer_sequencer #(
  parameter int depth = 2,
  parameter int A     = 7,
  parameter int LAT   = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [A-1:0] layerLength,
  input  logic         doPoolingIn,
  input  logic [A-1:0] ioAddress,
  input  logic         ioWrite,
  output logic         readBufferSelect,
  output logic         doPooling,
  output logic [A-1:0] readBuffAddress,
  output logic [A-1:0] writeBuffAddress,
  output logic         nRWrite,
  output logic         nWWrite,
  output logic         busy,
  output logic         done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] SWAP  = 2'd3;

  localparam logic [A-1:0] ONE = A'(1);

  logic [1:0]   state;
  logic [A-1:0] len_p0;
  logic [A-1:0] rd_cnt;
  logic [A-1:0] wr_cnt;
  logic [A-1:0] last_idx;
  logic [LAT-1:0] vld_p;
  logic         sel_r;
  logic         pool_r;
  logic         pushing;
  logic         wr_now;
  logic [LAT:0] vld_shift;

  assign last_idx  = len_p0 - ONE;
  assign pushing   = (state == READ);
  assign wr_now    = ((state == READ) || (state == DRAIN)) && vld_p[LAT-1];
  // vld_p[0] is the newest entry; the oldest bit drives the write strobe
  assign vld_shift = {vld_p, pushing};

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      len_p0 <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      vld_p  <= '0;
      sel_r  <= 1'b0;
      pool_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (layerLength != '0)) begin
            len_p0 <= layerLength;
            pool_r <= doPoolingIn;
            rd_cnt <= '0;
            wr_cnt <= '0;
            vld_p  <= '0;
            state  <= READ;
          end
        end
        READ: begin
          vld_p <= vld_shift[LAT-1:0];
          if (rd_cnt == last_idx) begin
            state <= DRAIN;
          end else begin
            rd_cnt <= rd_cnt + ONE;
          end
        end
        DRAIN: begin
          vld_p <= vld_shift[LAT-1:0];
        end
        default: begin
          sel_r <= ~sel_r;
          state <= IDLE;
        end
      endcase
      // Write side; the final write overrides any read-side transition
      if (wr_now) begin
        wr_cnt <= wr_cnt + ONE;
        if (wr_cnt == last_idx) begin
          state <= SWAP;
        end
      end
    end
  end

  always_comb begin
    readBuffAddress  = rd_cnt;
    nRWrite          = 1'b0;
    writeBuffAddress = wr_cnt;
    if (state == IDLE) begin
      readBuffAddress  = ioAddress;
      nRWrite          = ioWrite;
      writeBuffAddress = '0;
    end
  end

  assign nWWrite          = wr_now;
  assign busy             = (state != IDLE);
  assign done             = (state == SWAP);
  assign readBufferSelect = sel_r;
  assign doPooling        = pool_r;

endmodule

// File: tb/tb_neuron_buffer_sequencer.sv
// Randomized bench for neuron_buffer_sequencer against a cycle-schedule reference model.
module tb_neuron_buffer_sequencer;

  localparam int A   = 7;
  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [A-1:0] layerLength;
  logic         doPoolingIn;
  logic [A-1:0] ioAddress;
  logic         ioWrite;
  logic         readBufferSelect;
  logic         doPooling;
  logic [A-1:0] readBuffAddress;
  logic [A-1:0] writeBuffAddress;
  logic         nRWrite;
  logic         nWWrite;
  logic         busy;
  logic         done;

  neuron_buffer_sequencer #(.depth(2), .A(A), .LAT(LAT)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .layerLength(layerLength),
    .doPoolingIn(doPoolingIn),
    .ioAddress(ioAddress),
    .ioWrite(ioWrite),
    .readBufferSelect(readBufferSelect),
    .doPooling(doPooling),
    .readBuffAddress(readBuffAddress),
    .writeBuffAddress(writeBuffAddress),
    .nRWrite(nRWrite),
    .nWWrite(nWWrite),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Reference model: a pass is described only by its start cycle and length
  bit m_act  = 0;
  int m_t0   = 0;
  int m_L    = 0;
  bit m_sel  = 0;
  bit m_pool = 0;
  int n_done = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
  endtask

  task automatic step(input bit r, input bit s, input int len, input bit pin,
                      input int ioa, input bit iow);
    int k;
    int e_ra;
    bit e_done;
    @(negedge clk);
    reset       = r;
    start       = s;
    layerLength = A'(len);
    doPoolingIn = pin;
    ioAddress   = A'(ioa);
    ioWrite     = iow;
    #1;
    k = cyc - m_t0;
    chk("sel", int'(readBufferSelect), int'(m_sel));
    chk("pool", int'(doPooling), int'(m_pool));
    if (!m_act) begin
      chk("busy", int'(busy), 0);
      chk("done", int'(done), 0);
      chk("nWWrite", int'(nWWrite), 0);
      chk("waddr", int'(writeBuffAddress), 0);
      chk("raddr_io", int'(readBuffAddress), ioa);
      chk("nRWrite_io", int'(nRWrite), int'(iow));
    end else begin
      e_done = (k == LAT + m_L + 1);
      chk("busy", int'(busy), 1);
      chk("done", int'(done), int'(e_done));
      chk("nRWrite", int'(nRWrite), 0);
      if (k >= LAT + 1 && k <= LAT + m_L) begin
        chk("nWWrite", int'(nWWrite), 1);
        chk("waddr", int'(writeBuffAddress), k - 1 - LAT);
      end else begin
        chk("nWWrite", int'(nWWrite), 0);
      end
      if (!e_done) begin
        e_ra = (k <= m_L) ? k - 1 : m_L - 1;
        chk("raddr", int'(readBuffAddress), e_ra);
      end
      if (e_done) n_done++;
    end
    // Advance the model across the coming clock edge
    if (r) begin
      m_act  = 0;
      m_sel  = 0;
      m_pool = 0;
    end else if (m_act) begin
      if (k == LAT + m_L + 1) begin
        m_act = 0;
        m_sel = !m_sel;
      end
    end else if (s && len != 0) begin
      m_act  = 1;
      m_t0   = cyc;
      m_L    = len;
      m_pool = pin;
    end
    cyc++;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, $urandom_range(0, 127), $urandom_range(0, 1));
  endtask

  initial begin
    int d0;
    reset = 1; start = 0; layerLength = '0; doPoolingIn = 0; ioAddress = '0; ioWrite = 0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 5, 1);
    idle_n(3);

    // Single pass L=4, then back-to-back passes with pooling 1 then 0
    step(0, 1, 4, 0, 9, 0);
    idle_n(LAT + 4 + 1);
    step(0, 1, 4, 1, 0, 0);
    idle_n(LAT + 4 + 1);
    step(0, 1, 3, 0, 0, 0);
    idle_n(LAT + 3 + 3);

    // Zero-length start and a start pulsed mid-READ are both ignored
    d0 = n_done;
    step(0, 1, 0, 1, 7, 1);
    idle_n(2);
    step(0, 1, 5, 0, 0, 0);
    idle_n(1);
    step(0, 1, 9, 1, 0, 0);
    idle_n(LAT + 8);
    chk("done_count", n_done - d0, 1);

    // Reset in the cycle of the second write of an L=4 pass
    d0 = n_done;
    step(0, 1, 4, 1, 0, 0);
    idle_n(LAT + 1);
    step(1, 0, 0, 0, 0, 0);
    idle_n(8);
    chk("done_after_reset", n_done - d0, 0);

    // Longest legal pass
    d0 = n_done;
    step(0, 1, 127, 0, 0, 0);
    idle_n(LAT + 130);
    chk("done_long", n_done - d0, 1);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      int len;
      bit r;
      bit s;
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 19))
        0: len = 0;
        1: len = $urandom_range(1, 127);
        default: len = $urandom_range(1, 12);
      endcase
      if ($urandom_range(0, 99) == 0) begin
        r = 1;
        s = 1;
      end
      step(r, s, len, $urandom_range(0, 1), $urandom_range(0, 127), $urandom_range(0, 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
